// File: rtl/y86_pkg.sv
// Shared Y86-64 encoding constants and the encoder state type.
// Used by both the instruction length decoder and the loader.
package y86_pkg;

    localparam logic [3:0] HALT   = 4'h0;
    localparam logic [3:0] NOP    = 4'h1;
    localparam logic [3:0] CMOVXX = 4'h2;
    localparam logic [3:0] IRMOVQ = 4'h3;
    localparam logic [3:0] RMMOVQ = 4'h4;
    localparam logic [3:0] MRMOVQ = 4'h5;
    localparam logic [3:0] OPQ    = 4'h6;
    localparam logic [3:0] JXX    = 4'h7;
    localparam logic [3:0] CALL   = 4'h8;
    localparam logic [3:0] RET    = 4'h9;
    localparam logic [3:0] PUSHQ  = 4'hA;
    localparam logic [3:0] POPQ   = 4'hB;

    localparam logic [3:0] RNONE  = 4'hF;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL  = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EMIT,
        S_DONE
    } state_t;

endpackage

// File: rtl/y86_instr_len.sv
// Combinational icode decoder: legality, byte length and field layout.
// Shared with the fetch stage so both directions agree on the format.
module y86_instr_len
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    output logic       legal,
    output logic [3:0] len,
    output logic       has_regs,
    output logic       has_valc,
    output logic [3:0] valc_offset
);

    always_comb begin
        legal       = 1'b1;
        len         = 4'd0;
        has_regs    = 1'b0;
        has_valc    = 1'b0;
        valc_offset = 4'd0;
        case (icode)
            HALT, NOP, RET: len = 4'd1;
            CMOVXX, OPQ, PUSHQ, POPQ: begin
                len      = 4'd2;
                has_regs = 1'b1;
            end
            JXX, CALL: begin
                len         = 4'd9;
                has_valc    = 1'b1;
                valc_offset = 4'd1;
            end
            IRMOVQ, RMMOVQ, MRMOVQ: begin
                len         = 4'd10;
                has_regs    = 1'b1;
                has_valc    = 1'b1;
                valc_offset = 4'd2;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/y86_instr_encoder.sv
// Serializes one decoded Y86-64 instruction per handshake into instruction
// memory, one byte per cycle, advancing a write PC and flagging bad input.
module y86_instr_encoder
    import y86_pkg::*;
#(
    parameter int          MEM_BYTES = 80,
    parameter logic [63:0] BASE_PC   = 64'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic [63:0] valC,
    output logic        wr_en,
    output logic [63:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic [63:0] pc,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code
);

    logic            legal;
    logic            has_regs;
    logic            has_valc;
    logic [3:0]      len;
    logic [3:0]      valc_offset;
    logic [7:0]      reg_byte;
    logic [9:0][7:0] img;
    logic [9:0][7:0] img_q;
    logic [3:0]      len_q;
    logic [3:0]      idx;
    logic            halt_q;
    logic            fits;
    state_t          state;

    y86_instr_len u_len (
        .icode       (icode),
        .legal       (legal),
        .len         (len),
        .has_regs    (has_regs),
        .has_valc    (has_valc),
        .valc_offset (valc_offset)
    );

    // Build the full byte image up front so the latched copy is independent
    // of the input fields once the handshake has happened.
    always_comb begin
        reg_byte = {(icode == IRMOVQ) ? RNONE : rA,
                    (icode == PUSHQ || icode == POPQ) ? RNONE : rB};
        img    = '0;
        img[0] = {icode, ifun};
        if (has_regs)
            img[1] = reg_byte;
        if (has_valc) begin
            if (valc_offset == 4'd2)
                img[9:2] = valC;
            else
                img[8:1] = valC;
        end
    end

    assign fits     = ({1'b0, pc} + 65'(len)) <= 65'(MEM_BYTES);
    assign in_ready = (state == S_IDLE);
    assign done     = (state == S_DONE);

    // Byte k goes out with wr_addr equal to pc; pc steps past it on the
    // following edge, so pc always points at the next unwritten byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            pc       <= BASE_PC;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
            img_q    <= '0;
            len_q    <= '0;
            idx      <= '0;
            halt_q   <= 1'b0;
        end else if (clear) begin
            state    <= S_IDLE;
            pc       <= BASE_PC;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
            idx      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (!legal) begin
                            err      <= 1'b1;
                            err_code <= ERR_ILLEGAL;
                        end else if (!fits) begin
                            err      <= 1'b1;
                            err_code <= ERR_OVERFLOW;
                        end else begin
                            img_q   <= img;
                            len_q   <= len;
                            halt_q  <= (icode == HALT);
                            idx     <= 4'd1;
                            wr_en   <= 1'b1;
                            wr_addr <= pc;
                            wr_data <= img[0];
                            state   <= S_EMIT;
                        end
                    end
                end
                S_EMIT: begin
                    pc <= pc + 64'd1;
                    if (idx == len_q) begin
                        wr_en <= 1'b0;
                        state <= halt_q ? S_DONE : S_IDLE;
                    end else begin
                        wr_addr <= pc + 64'd1;
                        wr_data <= img_q[idx];
                        idx     <= idx + 4'd1;
                    end
                end
                S_DONE: ;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
